// File: rtl/tt_gate_seq.sv
// Sequenced truth-table gate: accepts an N_IN-bit index, waits SETTLE cycles, then registers tt_q[index].
// Optional runtime truth-table reload path and LOAD state enabled by defining TT_GATE_SEQ_RELOAD_EN.
module tt_gate_seq #(
  parameter int unsigned          N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] TT     = 8'hA6,
  parameter int unsigned          SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in_bits,
  output logic                 in_ready,
  output logic                 out,
  output logic                 out_valid,
  output logic                 out_chg,
  input  logic                 tt_load_valid,
  input  logic [(1<<N_IN)-1:0] tt_load_data,
  output logic                 tt_load_ready,
  output logic                 busy
);

  localparam int unsigned    TT_W     = 1 << N_IN;
  localparam int unsigned    CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e            state;
  state_e            state_d;
  logic [CW-1:0]     cnt;
  logic [N_IN-1:0]   idx_q;
  logic [TT_W-1:0]   tt_q;
  logic              in_acc;
  logic              load_acc;
  logic              eval_done;
  logic              result;

`ifdef TT_GATE_SEQ_RELOAD_EN
  // A pending load outranks a simultaneous input vector.
  assign tt_load_ready = (state == IDLE);
  assign in_ready      = (state == IDLE) && !tt_load_valid;
  assign load_acc      = tt_load_valid && tt_load_ready;

  // NOTE: tt_q is real configuration state, so it is reset to TT like any control register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q <= TT;
    end else if (load_acc) begin
      tt_q <= tt_load_data;
    end
  end
`else
  logic unused_load;

  assign tt_load_ready = 1'b0;
  assign in_ready      = (state == IDLE);
  assign load_acc      = 1'b0;
  assign tt_q          = TT;
  assign unused_load   = ^{tt_load_valid, tt_load_data};
`endif

  assign in_acc    = in_valid && in_ready;
  assign eval_done = (state == EVAL) && (cnt == '0);
  assign result    = tt_q[idx_q];
  assign busy      = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (load_acc) begin
          state_d = LOAD;
        end else if (in_acc) begin
          state_d = EVAL;
        end
      end
      EVAL:    if (cnt == '0) state_d = IDLE;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Counter counts down from SETTLE-1 and stops at zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      out_chg   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_chg   <= 1'b0;
      if (in_acc) begin
        idx_q <= in_bits;
        cnt   <= CNT_INIT;
      end else if (eval_done) begin
        out       <= result;
        out_valid <= 1'b1;
        out_chg   <= (result != out);
      end else if (state == EVAL) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_gate_seq.sv
// Self-checking bench for tt_gate_seq: vector table, hand-written corner sequences and
// randomized traffic against a truth-table reference model. Works with or without TT_GATE_SEQ_RELOAD_EN.
`timescale 1ns/1ps
module tb_tt_gate_seq;

  localparam int S0 = 4;
`ifdef TT_GATE_SEQ_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif
  localparam bit EXP1 = !RELOAD;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out, out_valid, out_chg;
  logic [2:0] in_bits;
  logic       tt_load_valid, tt_load_ready, busy;
  logic [7:0] tt_load_data;

  logic       in_valid_1, in_ready_1, out_1, out_valid_1, out_chg_1;
  logic [2:0] in_bits_1;
  logic       tt_load_valid_1, tt_load_ready_1, busy_1;
  logic [7:0] tt_load_data_1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_tt;
  logic       model_out;

  typedef struct {
    logic [2:0] bits;
    logic       exp_out;
    logic       exp_chg;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  tt_gate_seq #(.N_IN(3), .TT(8'hA6), .SETTLE(S0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_chg(out_chg), .tt_load_valid(tt_load_valid),
    .tt_load_data(tt_load_data), .tt_load_ready(tt_load_ready), .busy(busy)
  );

  tt_gate_seq #(.N_IN(3), .TT(8'hA6), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_bits(in_bits_1), .in_ready(in_ready_1),
    .out(out_1), .out_valid(out_valid_1), .out_chg(out_chg_1), .tt_load_valid(tt_load_valid_1),
    .tt_load_data(tt_load_data_1), .tt_load_ready(tt_load_ready_1), .busy(busy_1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offers one vector, measures accept-to-out_valid latency and checks the result.
  // With noise set, random in_valid/tt_load_valid traffic is driven while the block is busy.
  task automatic do_eval(input logic [2:0] bits, input logic exp_o, input logic exp_c,
                         input bit noise, input string nm);
    int w;
    int k;
    in_valid = 1'b1;
    in_bits  = bits;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_ready"}, in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    k = 0;
    in_valid      = noise;
    tt_load_valid = noise;
    in_bits       = 3'($urandom);
    tt_load_data  = 8'($urandom);
    while (!out_valid && k < S0 + 4) begin
      @(negedge clk);
      k++;
      in_valid      = noise && (k < S0);
      tt_load_valid = noise && (k < S0);
      in_bits       = 3'($urandom);
    end
    in_valid      = 1'b0;
    tt_load_valid = 1'b0;
    check({nm, "_latency"}, k, S0);
    check({nm, "_out"}, out, exp_o);
    check({nm, "_chg"}, out_chg, exp_c);
    check({nm, "_busy_done"}, busy, 0);
    check({nm, "_ready_done"}, in_ready, 1);
    @(negedge clk);
    check({nm, "_ov_pulse"}, out_valid, 0);
    check({nm, "_hold"}, out, exp_o);
  endtask

`ifdef TT_GATE_SEQ_RELOAD_EN
  task automatic do_load(input logic [7:0] data);
    tt_load_valid = 1'b1;
    tt_load_data  = data;
    check("load_ready", tt_load_ready, 1);
    check("load_blocks_in", in_ready, 0);
    @(negedge clk);
    tt_load_valid = 1'b0;
    check("load_busy", busy, 1);
    check("load_state_ready", tt_load_ready, 0);
    check("load_state_in_ready", in_ready, 0);
    @(negedge clk);
    check("load_back_idle", in_ready, 1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0] b;
    logic       e;
    rst = 1'b1;
    in_valid = 1'b0; in_bits = '0; tt_load_valid = 1'b0; tt_load_data = '0;
    in_valid_1 = 1'b0; in_bits_1 = '0; tt_load_valid_1 = 1'b0; tt_load_data_1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_chg", out_chg, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_load_ready", tt_load_ready, RELOAD);
    check("rst_in_ready_1", in_ready_1, 1);

    // SETTLE=1 instance: load pulse (ignored without reload), then index 1.
    tt_load_valid_1 = 1'b1;
    tt_load_data_1  = 8'h00;
`ifndef TT_GATE_SEQ_RELOAD_EN
    check("s1_load_ready_a", tt_load_ready_1, 0);
`endif
    @(negedge clk);
    tt_load_valid_1 = 1'b0;
    check("s1_load_ready_b", tt_load_ready_1, 0);
    @(negedge clk);
    in_valid_1 = 1'b1;
    in_bits_1  = 3'b001;
    check("s1_in_ready", in_ready_1, 1);
    @(negedge clk);
    in_valid_1 = 1'b0;
    check("s1_no_early_ov", out_valid_1, 0);
    @(negedge clk);
    check("s1_out_valid", out_valid_1, 1);
    check("s1_out", out_1, EXP1);
    check("s1_chg", out_chg_1, EXP1);
`ifndef TT_GATE_SEQ_RELOAD_EN
    check("s1_load_ready_c", tt_load_ready_1, 0);
`endif
    @(negedge clk);
    check("s1_ov_pulse", out_valid_1, 0);

    // Default table walk, indices 0..7.
    tbl[0] = '{3'd0, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 1'b1, 1'b1};
    tbl[2] = '{3'd2, 1'b1, 1'b0};
    tbl[3] = '{3'd3, 1'b0, 1'b1};
    tbl[4] = '{3'd4, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 1'b1, 1'b1};
    tbl[6] = '{3'd6, 1'b0, 1'b1};
    tbl[7] = '{3'd7, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_eval(tbl[i].bits, tbl[i].exp_out, tbl[i].exp_chg, 1'b0, $sformatf("tbl%0d", i));
    end

`ifdef TT_GATE_SEQ_RELOAD_EN
    do_load(8'h96);
    do_eval(3'b111, 1'b1, 1'b0, 1'b0, "reload_111");
    do_eval(3'b011, 1'b0, 1'b1, 1'b0, "reload_011");

    // Simultaneous load and input: load wins, input goes two cycles later against 8'h5A.
    in_valid      = 1'b1;
    in_bits       = 3'd6;
    tt_load_valid = 1'b1;
    tt_load_data  = 8'h5A;
    check("simul_in_ready", in_ready, 0);
    check("simul_load_ready", tt_load_ready, 1);
    @(negedge clk);
    tt_load_valid = 1'b0;
    check("simul_busy_load", busy, 1);
    check("simul_in_ready_load", in_ready, 0);
    @(negedge clk);
    check("simul_in_ready_after", in_ready, 1);
    do_eval(3'd6, 1'b1, 1'b1, 1'b0, "simul");
    do_eval(3'd1, 1'b1, 1'b0, 1'b0, "pre_rst");
`else
    tt_load_valid = 1'b1;
    tt_load_data  = 8'h96;
    check("noload_ready", tt_load_ready, 0);
    check("noload_in_ready", in_ready, 1);
    @(negedge clk);
    tt_load_valid = 1'b0;
    check("noload_busy", busy, 0);
    do_eval(3'b011, 1'b0, 1'b1, 1'b0, "noload_011");
    in_valid      = 1'b1;
    in_bits       = 3'd6;
    tt_load_valid = 1'b1;
    tt_load_data  = 8'h5A;
    check("simul_in_ready", in_ready, 1);
    do_eval(3'd6, 1'b0, 1'b0, 1'b0, "simul");
    do_eval(3'd1, 1'b1, 1'b1, 1'b0, "pre_rst");
`endif

    // Reset two cycles into an evaluation.
    in_valid = 1'b1;
    in_bits  = 3'd2;
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy_after", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_out_valid", seen, 0);
    check("midrst_out_held", out, 0);
    do_eval(3'd5, 1'b1, 1'b1, 1'b0, "post_rst_tt");

    // Randomized traffic against the truth-table model.
    model_tt  = 8'hA6;
    model_out = 1'b1;
    for (int it = 0; it < 40; it++) begin
`ifdef TT_GATE_SEQ_RELOAD_EN
      if ($urandom_range(0, 3) == 0) begin
        model_tt = 8'($urandom);
        do_load(model_tt);
        continue;
      end
`endif
      b = 3'($urandom);
      e = model_tt[b];
      do_eval(b, e, e != model_out, 1'($urandom), $sformatf("rand%0d", it));
      model_out = e;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check($sformatf("rand%0d_idle_hold", it), out, model_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
